// File: rtl/des_cbc_ctrl_if.sv
// Streaming block interface for the DES chaining controller: 64-bit input
// and output blocks, each with its own valid/ready handshake.
interface des_cbc_ctrl_if;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/des_cbc_ctrl.sv
// CBC/ECB chaining controller for an iterative DES core: programs the key,
// feeds one block at a time, chains results and watchdogs core completion.
module des_cbc_ctrl #(
  parameter int TIMEOUT = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clk_en,
  input  logic [63:0] i_cfg_key,
  input  logic [63:0] i_cfg_iv,
  input  logic        i_cfg_mode,
  input  logic        i_cfg_chain,
  input  logic        i_cfg_load,
  output logic        o_cfg_done,
  output logic        o_err,
  des_cbc_ctrl_if.slave s_blk,
  output logic [63:0] o_core_data_in,
  output logic        o_core_data_en,
  output logic [63:0] o_core_key,
  output logic        o_core_mode,
  output logic        o_core_key_en,
  input  logic [63:0] i_core_data_out,
  input  logic        i_core_busy,
  input  logic        i_core_wr
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  localparam logic [2:0] S_UNCONF  = 3'd0;
  localparam logic [2:0] S_KEY     = 3'd1;
  localparam logic [2:0] S_KEYWAIT = 3'd2;
  localparam logic [2:0] S_READY   = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_OUT     = 3'd5;
  localparam logic [2:0] S_ERR     = 3'd6;

  logic [2:0]    r_state;
  logic [63:0]   r_key;
  logic          r_mode;
  logic          r_chainEn;
  logic [63:0]   r_chain;
  logic [63:0]   r_hold;
  logic [63:0]   r_coreIn;
  logic          r_dataEn;
  logic [TW-1:0] r_timer;
  logic [63:0]   r_outData;
  logic          r_outValid;
  logic          r_err;

  logic          w_inReady;
  logic          w_accept;
  logic          w_cfgAccept;
  logic [63:0]   w_blockIn;
  logic [63:0]   w_res;
  logic          w_unused;

  // cfg_load has priority over a same-cycle input block
  assign w_inReady   = (r_state == S_READY) && !i_cfg_load;
  assign w_accept    = w_inReady && s_blk.in_valid;
  assign w_cfgAccept = i_cfg_load &&
                       ((r_state == S_UNCONF) || (r_state == S_READY) || (r_state == S_ERR));
  assign w_blockIn   = (r_chainEn && !r_mode) ? (s_blk.in_data ^ r_chain) : s_blk.in_data;
  assign w_res       = (r_chainEn && r_mode) ? (i_core_data_out ^ r_chain) : i_core_data_out;
  assign w_unused    = i_core_busy;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_UNCONF;
      r_key      <= '0;
      r_mode     <= 1'b0;
      r_chainEn  <= 1'b0;
      r_chain    <= '0;
      r_hold     <= '0;
      r_coreIn   <= '0;
      r_dataEn   <= 1'b0;
      r_timer    <= '0;
      r_outData  <= '0;
      r_outValid <= 1'b0;
      r_err      <= 1'b0;
    end else if (i_clk_en) begin
      r_dataEn <= 1'b0;
      if (w_cfgAccept) begin
        r_key     <= i_cfg_key;
        r_mode    <= i_cfg_mode;
        r_chainEn <= i_cfg_chain;
        r_chain   <= i_cfg_iv;
        r_err     <= 1'b0;
        r_state   <= S_KEY;
      end else begin
        case (r_state)
          S_KEY:     r_state <= S_KEYWAIT;
          S_KEYWAIT: r_state <= S_READY;
          S_READY: begin
            if (w_accept) begin
              r_coreIn <= w_blockIn;
              r_hold   <= s_blk.in_data;
              r_dataEn <= 1'b1;
              r_timer  <= '0;
              r_state  <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (i_core_wr) begin
              r_outData  <= w_res;
              r_outValid <= 1'b1;
              if (r_chainEn) begin
                r_chain <= r_mode ? r_hold : i_core_data_out;
              end
              r_state <= S_OUT;
            end else if (r_timer == TIMER_LAST) begin
              r_err   <= 1'b1;
              r_state <= S_ERR;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
          S_OUT: begin
            if (r_outValid && s_blk.out_ready) begin
              r_outValid <= 1'b0;
              r_state    <= S_READY;
            end
          end
          S_UNCONF, S_ERR: r_state <= r_state;
          default:   r_state <= S_UNCONF;
        endcase
      end
    end
  end

  assign o_cfg_done      = (r_state == S_READY);
  assign o_err           = r_err;
  assign o_core_data_in  = r_coreIn;
  assign o_core_data_en  = r_dataEn;
  assign o_core_key      = r_key;
  assign o_core_mode     = r_mode;
  assign o_core_key_en   = (r_state == S_KEY);
  assign s_blk.in_ready  = w_inReady;
  assign s_blk.out_data  = r_outData;
  assign s_blk.out_valid = r_outValid;

endmodule
